branch_sequencer: RTL and testbench
===================================

// Module: branch_sequencer
// PURPOSE
//  Sequences conditional branches between issue and fetch. Holds the architectural Z/V/N flags.
//  Stalls a branch while a flag-setting instruction is still in flight, then resolves the condition.
//  On a taken branch it issues a one-cycle PC redirect and a pipeline flush of fixed length.
//  Keeps a saturating count of taken branches for performance monitoring.
// PARAMETERS
//  PC_WIDTH      16  width of branch target / redirect PC
//  FLUSH_CYCLES  2   cycles oFlush is held per taken branch, legal 1..7
// PORTS
//  iClk            in   1         clock, all state on rising edge
//  iRst            in   1         asynchronous, active-high reset
//  iBranchValid    in   1         branch instruction offered by issue
//  oBranchReady    out  1         sequencer accepts branch; transfer = iBranchValid & oBranchReady
//  iBranchOp       in   3         condition: 0 NEQ,1 EQ,2 GT,3 LT,4 GTE,5 LTE,6 OVFL,7 UNCON
//  iBranchTarget   in   PC_WIDTH  target PC, captured on transfer
//  iFlagPending    in   1         flag-setting instruction issued but flags not yet written
//  iFlagWrite      in   1         ALU writes flags this cycle
//  iZeroFlag       in   1         ALU zero result
//  iOverflowFlag   in   1         ALU overflow result
//  iNegativeFlag   in   1         ALU negative result
//  oZeroFlag       out  1         registered architectural Z
//  oOverflowFlag   out  1         registered architectural V
//  oNegativeFlag   out  1         registered architectural N
//  oStall          out  1         hold issue; branch waiting on flags
//  oRedirect       out  1         one-cycle pulse: fetch must load oRedirectPC
//  oRedirectPC     out  PC_WIDTH  captured target, valid while oRedirect=1
//  oFlush          out  1         squash younger instructions
//  oTakenCount     out  16        taken-branch counter, saturates at 16'hFFFF
// BEHAVIOUR
//  Reset (async, any state): FSM=IDLE; flags, captured op/target, flush counter, oTakenCount = 0.
//   All outputs are 0 while iRst=1, except oBranchReady, which is 1 once iRst deasserts (IDLE).
//  Flag register: when iFlagWrite=1, it loads Z/V/N at the edge; otherwise it holds. Writes occur in every FSM state.
//  Condition (from registered flags only): NEQ ~Z; EQ Z; GT ~Z&~N; LT N; GTE ~N; LTE N|Z; OVFL V; UNCON 1.
//  IDLE: oBranchReady=1. On transfer, capture op and target.
//   If iFlagPending=1 and op!=UNCON -> WAIT, else -> EVAL.
//  WAIT: oStall=1, oBranchReady=0. When iFlagPending=0 -> EVAL.
//   A flag write in that same cycle is visible in EVAL.
//  EVAL (exactly 1 cycle): oBranchReady=0. Evaluate condition.
//   Taken: oRedirect=1, oFlush=1, oRedirectPC=target, oTakenCount+1 (saturating).
//    If FLUSH_CYCLES=1 -> IDLE, else -> FLUSH with counter=FLUSH_CYCLES-1.
//   Not taken: outputs 0, -> IDLE.
//  FLUSH: oFlush=1, oBranchReady=0. Decrement counter; at 1 -> IDLE.
//   Total oFlush length = FLUSH_CYCLES, including the EVAL cycle.
//  Latency: transfer at cycle T with no pending flags -> oRedirect at T+1; next branch accepted at T+1+FLUSH_CYCLES.
//   Not-taken: next accept at T+2.
//  iFlagWrite during EVAL does not affect that evaluation; it updates the register for later branches.
//  oRedirect, oFlush and oStall are decoded from registered state/captured values: glitch-free, no input-to-output combinational path.
//  oRedirectPC holds its last captured value when oRedirect=0.
//  iBranchValid outside IDLE is ignored (not accepted); issue must hold it until oBranchReady.
//  iRst mid-WAIT/EVAL/FLUSH: the branch is dropped; no redirect is emitted after reset release.
// TESTING
//  1 Flags Z=1 written; EQ branch, target 16'h0040, no pending -> oRedirect=1 one cycle later, PC=0040, oFlush 2 cycles, count=1.
//  2 Flags Z=1; NEQ branch -> no redirect, no flush, oBranchReady=1 two cycles after transfer, count unchanged.
//  3 iFlagPending=1 for 3 cycles, then a write of N=1, with LT branch -> oStall=1 for 3 cycles, then redirect on the cycle after pending drops.
//  4 UNCON with iFlagPending=1 -> no stall, redirect at T+1. Also preload count 16'hFFFF -> stays FFFF.
//  5 Sweep all 8 ops x 8 flag combinations -> oRedirect matches the condition table exactly.
//  6 Assert iRst in WAIT and in FLUSH -> all outputs 0 immediately. After release: IDLE, oBranchReady=1, no stray redirect.

Source files
------------

// File: rtl/branch_sequencer.sv
// branch_sequencer: holds Z/V/N, stalls branches on in-flight flags, resolves them and issues redirect plus flush.
// TAKEN_CNT_INIT is the reset value of the taken counter; leave it 0 except to observe saturation quickly.
module branch_sequencer #(
  parameter int PC_WIDTH = 16,
  parameter int FLUSH_CYCLES = 2,
  parameter logic [15:0] TAKEN_CNT_INIT = 16'h0000
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iBranchValid,
  output logic                oBranchReady,
  input  logic [2:0]          iBranchOp,
  input  logic [PC_WIDTH-1:0] iBranchTarget,
  input  logic                iFlagPending,
  input  logic                iFlagWrite,
  input  logic                iZeroFlag,
  input  logic                iOverflowFlag,
  input  logic                iNegativeFlag,
  output logic                oZeroFlag,
  output logic                oOverflowFlag,
  output logic                oNegativeFlag,
  output logic                oStall,
  output logic                oRedirect,
  output logic [PC_WIDTH-1:0] oRedirectPC,
  output logic                oFlush,
  output logic [15:0]         oTakenCount
);
  typedef enum logic [1:0] {IDLE, WAIT, EVAL, FLUSH} state_t;
  state_t state_q, state_d;
  logic z_q, z_d, v_q, v_d, n_q, n_d;
  logic [2:0] op_q, op_d, flush_cnt_q, flush_cnt_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0] cond;
  logic taken;
  // one condition bit per op encoding, UNCON at the top
  assign cond = {1'b1, v_q, n_q | z_q, ~n_q, n_q, ~z_q & ~n_q, z_q, ~z_q};
  assign taken = cond[op_q];
  always_comb begin
    state_d = state_q;
    {z_d, v_d, n_d} = iFlagWrite ? {iZeroFlag, iOverflowFlag, iNegativeFlag} : {z_q, v_q, n_q};
    op_d = op_q;
    pc_d = pc_q;
    flush_cnt_d = flush_cnt_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (iBranchValid) begin
        op_d = iBranchOp;
        pc_d = iBranchTarget;
        state_d = (iFlagPending && iBranchOp != 3'd7) ? WAIT : EVAL;
      end
      WAIT: state_d = iFlagPending ? WAIT : EVAL;
      EVAL: begin
        state_d = (taken && FLUSH_CYCLES > 1) ? FLUSH : IDLE;
        flush_cnt_d = 3'(FLUSH_CYCLES - 1);
        cnt_d = (taken && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
      end
      default: begin
        flush_cnt_d = flush_cnt_q - 3'd1;
        state_d = (flush_cnt_q == 3'd1) ? IDLE : FLUSH;
      end
    endcase
  end
  always_ff @(posedge iClk or posedge iRst)
    if (iRst) begin
      state_q <= IDLE;
      {z_q, v_q, n_q} <= 3'b000;
      op_q <= 3'd0;
      pc_q <= '0;
      flush_cnt_q <= 3'd0;
      cnt_q <= TAKEN_CNT_INIT;
    end else begin
      state_q <= state_d;
      {z_q, v_q, n_q} <= {z_d, v_d, n_d};
      op_q <= op_d;
      pc_q <= pc_d;
      flush_cnt_q <= flush_cnt_d;
      cnt_q <= cnt_d;
    end
  assign oBranchReady = (state_q == IDLE) & ~iRst;
  assign oStall = state_q == WAIT;
  assign oRedirect = (state_q == EVAL) & taken;
  assign oFlush = oRedirect | (state_q == FLUSH);
  assign oRedirectPC = pc_q;
  assign {oZeroFlag, oOverflowFlag, oNegativeFlag} = {z_q, v_q, n_q};
  assign oTakenCount = cnt_q;
endmodule

// File: tb/tb_branch_sequencer.sv
// tb_branch_sequencer: directed and randomized branches checked cycle by cycle against a transaction-level model.
module tb_branch_sequencer;
  localparam int F = 2;
  localparam logic [15:0] INIT = 16'hFFFC;
  logic iClk = 0, iRst = 0, iBranchValid = 0, iFlagPending = 0, iFlagWrite = 0;
  logic iZeroFlag = 0, iOverflowFlag = 0, iNegativeFlag = 0;
  logic [2:0] iBranchOp = 0;
  logic [15:0] iBranchTarget = 0;
  logic oBranchReady, oZeroFlag, oOverflowFlag, oNegativeFlag, oStall, oRedirect, oFlush;
  logic [15:0] oRedirectPC, oTakenCount;
  int nvec = 0, nerr = 0;
  logic mz = 0, mv = 0, mn = 0;
  logic [15:0] mcnt = INIT;
  always #5 iClk = ~iClk;
  branch_sequencer #(.PC_WIDTH(16), .FLUSH_CYCLES(F), .TAKEN_CNT_INIT(INIT)) dut (
    .iClk(iClk), .iRst(iRst), .iBranchValid(iBranchValid), .oBranchReady(oBranchReady),
    .iBranchOp(iBranchOp), .iBranchTarget(iBranchTarget), .iFlagPending(iFlagPending),
    .iFlagWrite(iFlagWrite), .iZeroFlag(iZeroFlag), .iOverflowFlag(iOverflowFlag),
    .iNegativeFlag(iNegativeFlag), .oZeroFlag(oZeroFlag), .oOverflowFlag(oOverflowFlag),
    .oNegativeFlag(oNegativeFlag), .oStall(oStall), .oRedirect(oRedirect),
    .oRedirectPC(oRedirectPC), .oFlush(oFlush), .oTakenCount(oTakenCount)
  );
  function automatic bit cond(input logic [2:0] op, input logic z, input logic v, input logic n);
    case (op)
      3'd0: return !z;
      3'd1: return z;
      3'd2: return !z && !n;
      3'd3: return n;
      3'd4: return !n;
      3'd5: return n || z;
      3'd6: return v;
      default: return 1'b1;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge iClk);
    if (iFlagWrite && !iRst) {mz, mv, mn} = {iZeroFlag, iOverflowFlag, iNegativeFlag};
    #1;
  endtask
  task automatic chk_flags(input string tag);
    chk(tag, {oZeroFlag, oOverflowFlag, oNegativeFlag}, {mz, mv, mn});
  endtask
  task automatic set_flags(input logic [2:0] f);
    iFlagWrite = 1;
    {iZeroFlag, iOverflowFlag, iNegativeFlag} = f;
    tick();
    iFlagWrite = 0;
    chk_flags("flag_write");
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {oBranchReady, oStall, oRedirect, oFlush, oZeroFlag, oOverflowFlag, oNegativeFlag}, 0);
    chk({tag, "_pc"}, oRedirectPC, 0);
    chk({tag, "_cnt"}, oTakenCount, INIT);
  endtask
  task automatic do_reset(input string tag);
    iRst = 1;
    iBranchValid = 0;
    iFlagPending = 0;
    iFlagWrite = 0;
    #1;
    chk_zero(tag);
    {mz, mv, mn} = 3'b000;
    mcnt = INIT;
    @(posedge iClk);
    #1;
    chk_zero(tag);
    iRst = 0;
    #1;
    chk({tag, "_ready"}, oBranchReady, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_quiet"}, {oStall, oRedirect, oFlush, oBranchReady}, 4'b0001);
    end
  endtask
  // s>0 holds iFlagPending for s cycles from the transfer and writes wf as it drops; ewr writes ef during EVAL
  task automatic branch(input logic [2:0] op, input logic [15:0] tgt, input int s,
                        input logic [2:0] wf, input bit ewr, input logic [2:0] ef);
    int stall, fin;
    bit tk;
    stall = (s > 0 && op != 3'd7) ? s : 0;
    fin = 1000;
    tk = 0;
    chk("ready_before", oBranchReady, 1);
    for (int k = 0; k < fin || k <= s; k++) begin
      iBranchValid = (k == 0) || (k < fin && $urandom_range(0, 1) == 1);
      iBranchOp = (k == 0) ? op : 3'($urandom);
      iBranchTarget = (k == 0) ? tgt : 16'($urandom);
      iFlagPending = k < s;
      iFlagWrite = (s > 0 && k == s) || (ewr && k == stall + 1);
      {iZeroFlag, iOverflowFlag, iNegativeFlag} = (s > 0 && k == s) ? wf : ef;
      tick();
      if (k == stall) begin
        tk = cond(op, mz, mv, mn);
        fin = stall + 1 + (tk ? F : 1);
        if (tk && mcnt != 16'hFFFF) mcnt = mcnt + 16'd1;
        if (tk) chk("redirect_pc", oRedirectPC, tgt);
      end
      chk("stall", oStall, k + 1 <= stall);
      chk("redirect", oRedirect, (k + 1 == stall + 1) && tk);
      chk("flush", oFlush, tk && k + 1 >= stall + 1 && k + 1 <= stall + F);
      chk("ready", oBranchReady, k + 1 >= fin);
      chk_flags("flags");
    end
    iBranchValid = 0;
    iFlagPending = 0;
    iFlagWrite = 0;
    chk("taken_count", oTakenCount, mcnt);
  endtask
  initial begin
    #2;
    do_reset("reset");
    set_flags(3'b100);
    branch(3'd1, 16'h0040, 0, 3'b000, 0, 3'b000);
    branch(3'd0, 16'($urandom), 0, 3'b000, 0, 3'b000);
    set_flags(3'b000);
    branch(3'd3, 16'h1234, 3, 3'b001, 0, 3'b000);
    branch(3'd7, 16'hBEEF, 2, 3'b000, 1, 3'b111);
    for (int op = 0; op < 8; op++)
      for (int f = 0; f < 8; f++) begin
        set_flags(3'(f));
        branch(3'(op), 16'($urandom), 0, 3'b000, $urandom_range(0, 1) == 1, 3'($urandom));
      end
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 1) == 1) set_flags(3'($urandom));
      branch(3'($urandom), 16'($urandom), $urandom_range(0, 3), 3'($urandom),
             $urandom_range(0, 1) == 1, 3'($urandom));
    end
    set_flags(3'b100);
    iBranchValid = 1;
    iBranchOp = 3'd1;
    iBranchTarget = 16'h0ABC;
    iFlagPending = 1;
    tick();
    iBranchValid = 0;
    tick();
    chk("wait_before_rst", oStall, 1);
    do_reset("rst_wait");
    iBranchValid = 1;
    iBranchOp = 3'd7;
    iBranchTarget = 16'h0F0F;
    tick();
    iBranchValid = 0;
    chk("uncon_redirect", oRedirect, 1);
    tick();
    chk("flush_before_rst", {oFlush, oRedirect}, 2'b10);
    do_reset("rst_flush");
    branch(3'd7, 16'h5555, 0, 3'b000, 0, 3'b000);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
